sha2_msg_schedule: RTL and testbench

SHA2_MSG_SCHEDULE -- requirements
Module: sha2_msg_schedule

---
 rtl/sha2_msg_schedule.sv | 116 +++++++++++
 tb/tb_sha2_msg_schedule.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_msg_schedule.sv
// SHA-256 / SHA-512 message schedule generator: accepts 16 message words and
// emits the R-word expanded schedule through a sliding 16-word window.
module sha2_msg_schedule #(
    parameter int SHA512 = 0,
    localparam int W = (SHA512 != 0) ? 64 : 32,
    localparam int R = (SHA512 != 0) ? 80 : 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [6:0]   out_idx,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] win [16];
    logic [6:0]   cnt;
    logic         in_hs, out_hs, cnt_end;
    logic [W-1:0] w_new;

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
        return (x >> n) | (x << (W - n));
    endfunction

    function automatic logic [W-1:0] sig0(input logic [W-1:0] x);
        if (SHA512 != 0)
            return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
        else
            return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [W-1:0] sig1(input logic [W-1:0] x);
        if (SHA512 != 0)
            return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
        else
            return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign in_hs   = in_valid && in_ready;
    assign out_hs  = out_valid && out_ready;
    assign cnt_end = (cnt == 7'(R - 1));
    // Modulo-2^W sum falls out of the W-bit result width.
    assign w_new   = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_hs) state_nxt = LOAD;
                LOAD:    if (in_hs && cnt == 7'd15) state_nxt = EXPAND;
                EXPAND:  if (out_hs && cnt_end) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        busy      = (state != IDLE);
        if (state == EXPAND) begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            out_data  = win[0];
            out_idx   = cnt;
            out_last  = cnt_end;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE:    if (in_hs) cnt <= 7'd1;
                LOAD:    if (in_hs) cnt <= (cnt == 7'd15) ? 7'd0 : cnt + 7'd1;
                EXPAND:  if (out_hs) cnt <= cnt_end ? 7'd0 : cnt + 7'd1;
                default: cnt <= '0;
            endcase
        end
    end

    // Loading and expansion share one shift; only the word entering win[15] differs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (!flush && (in_hs || out_hs)) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= in_hs ? in_data : w_new;
        end
    end

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// Bench for sha2_msg_schedule: one SHA-256 and one SHA-512 instance checked
// against a direct recurrence model of the message schedule.
module tb_sha2_msg_schedule;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        iv = 1'b0;
    logic [63:0] id = '0;
    logic        ordy = 1'b0;
    logic        flsh = 1'b0;

    logic        ir_a, ov_a, ol_a, bz_a;
    logic [31:0] od_a;
    logic [6:0]  oi_a;
    logic        ir_b, ov_b, ol_b, bz_b;
    logic [63:0] od_b;
    logic [6:0]  oi_b;

    logic        ir, ov, ol, bz;
    logic [63:0] od;
    logic [6:0]  oi;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] msg  [16];
    logic [63:0] expw [80];
    logic [63:0] got  [80];

    always #5 clk = ~clk;

    sha2_msg_schedule #(.SHA512(0)) dut_a (
        .clk(clk), .rst(rst), .flush(flsh & ~sel),
        .in_valid(iv & ~sel), .in_ready(ir_a), .in_data(id[31:0]),
        .out_valid(ov_a), .out_ready(ordy & ~sel), .out_data(od_a),
        .out_idx(oi_a), .out_last(ol_a), .busy(bz_a)
    );

    sha2_msg_schedule #(.SHA512(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flsh & sel),
        .in_valid(iv & sel), .in_ready(ir_b), .in_data(id),
        .out_valid(ov_b), .out_ready(ordy & sel), .out_data(od_b),
        .out_idx(oi_b), .out_last(ol_b), .busy(bz_b)
    );

    assign ir = sel ? ir_b : ir_a;
    assign ov = sel ? ov_b : ov_a;
    assign ol = sel ? ol_b : ol_a;
    assign bz = sel ? bz_b : bz_a;
    assign od = sel ? od_b : {32'h0, od_a};
    assign oi = sel ? oi_b : oi_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rotr_m(input logic [63:0] x, input int n);
        logic [31:0] y;
        if (sel) return (x >> n) | (x << (64 - n));
        y = x[31:0];
        return {32'h0, (y >> n) | (y << (32 - n))};
    endfunction

    function automatic logic [63:0] s0_m(input logic [63:0] x);
        if (sel) return rotr_m(x, 1) ^ rotr_m(x, 8) ^ (x >> 7);
        return rotr_m(x, 7) ^ rotr_m(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] s1_m(input logic [63:0] x);
        if (sel) return rotr_m(x, 19) ^ rotr_m(x, 61) ^ (x >> 6);
        return rotr_m(x, 17) ^ rotr_m(x, 19) ^ (x >> 10);
    endfunction

    // Textbook recurrence W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
    task automatic build_ref();
        logic [63:0] s;
        int r;
        r = sel ? 80 : 64;
        for (int t = 0; t < 16; t++) expw[t] = msg[t];
        for (int t = 16; t < r; t++) begin
            s = s1_m(expw[t-2]) + expw[t-7] + s0_m(expw[t-15]) + expw[t-16];
            if (!sel) s[63:32] = '0;
            expw[t] = s;
        end
    endtask

    task automatic rand_msg();
        for (int i = 0; i < 16; i++) begin
            msg[i] = {$urandom, $urandom};
            if (!sel) msg[i][63:32] = '0;
        end
        build_ref();
    endtask

    task automatic abc_msg();
        for (int i = 0; i < 16; i++) msg[i] = '0;
        msg[0]  = sel ? 64'h6162638000000000 : 64'h0000000061626380;
        msg[15] = 64'h18;
        build_ref();
    endtask

    // Called and returns at a negedge.
    task automatic load_block(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    iv = 1'b0;
                    @(negedge clk);
                end
            end
            iv = 1'b1;
            id = msg[i];
            chk("load_in_ready", 64'(ir), 64'd1);
            chk("load_out_valid", 64'(ov), 64'd0);
            if (i > 0) chk("load_busy", 64'(bz), 64'd1);
            @(negedge clk);
        end
        iv = 1'b0;
    endtask

    task automatic drain(input int stop, input bit bp);
        int idx, budget, r;
        logic [63:0] cur;
        idx = 0;
        budget = 2000;
        r = sel ? 80 : 64;
        while (idx < stop && budget > 0) begin
            cur = od;
            chk("out_valid", 64'(ov), 64'd1);
            chk("out_data", cur, expw[idx]);
            chk("out_idx", 64'(oi), 64'(idx));
            chk("out_last", 64'(ol), 64'(idx == r - 1));
            chk("exp_in_ready", 64'(ir), 64'd0);
            ordy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            iv   = bp ? 1'($urandom_range(0, 1)) : 1'b0;
            id   = {$urandom, $urandom};
            @(negedge clk);
            budget--;
            if (ordy) begin
                got[idx] = cur;
                idx++;
            end
        end
        iv = 1'b0;
        if (budget == 0) chk("drain_timeout", 64'd0, 64'd1);
        if (stop == r) begin
            ordy = 1'b0;
            chk("end_out_valid", 64'(ov), 64'd0);
            chk("end_in_ready", 64'(ir), 64'd1);
            chk("end_busy", 64'(bz), 64'd0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(ov_a), 64'd0);
        chk("rst_data", 64'(od_a), 64'd0);
        chk("rst_idx", 64'(oi_a), 64'd0);
        chk("rst_last", 64'(ol_a), 64'd0);
        chk("rst_busy_a", 64'(bz_a), 64'd0);
        chk("rst_busy_b", 64'(bz_b), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(ir_a), 64'd1);

        // SHA-256 "abc" block, full throughput
        abc_msg();
        load_block(16, 1'b0);
        drain(64, 1'b0);
        chk("abc256_w16", got[16], 64'h61626380);
        chk("abc256_w17", got[17], 64'h000F0000);

        // Same stream under input gaps and output backpressure
        load_block(16, 1'b1);
        drain(64, 1'b1);
        chk("bp_w17", got[17], 64'h000F0000);

        // SHA-512 "abc" block
        sel = 1'b1;
        abc_msg();
        load_block(16, 1'b0);
        drain(80, 1'b0);
        chk("abc512_w16", got[16], 64'h6162638000000000);
        chk("abc512_w17", got[17], 64'h00030000000000C0);
        chk("abc512_w79", got[79], expw[79]);
        sel = 1'b0;
        @(negedge clk);

        // Flush at out_idx 20 with a handshake pending
        rand_msg();
        load_block(16, 1'b0);
        drain(20, 1'b0);
        chk("flush_idx", 64'(oi), 64'd20);
        ordy = 1'b1;
        flsh = 1'b1;
        @(negedge clk);
        flsh = 1'b0;
        ordy = 1'b0;
        chk("flush_valid", 64'(ov), 64'd0);
        chk("flush_busy", 64'(bz), 64'd0);
        chk("flush_ready", 64'(ir), 64'd1);
        @(negedge clk);
        chk("flush_valid2", 64'(ov), 64'd0);
        rand_msg();
        load_block(16, 1'b0);
        drain(64, 1'b1);

        // Reset pulse after 9 loaded words
        rand_msg();
        load_block(9, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(ov_a), 64'd0);
        chk("midrst_data", 64'(od_a), 64'd0);
        chk("midrst_idx", 64'(oi_a), 64'd0);
        chk("midrst_last", 64'(ol_a), 64'd0);
        chk("midrst_busy", 64'(bz_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 64'(ir_a), 64'd1);
        rand_msg();
        load_block(16, 1'b0);
        drain(64, 1'b0);

        // Back-to-back blocks: second load starts on the single idle cycle
        rand_msg();
        load_block(16, 1'b0);
        drain(64, 1'b0);
        rand_msg();
        load_block(16, 1'b0);
        drain(64, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
